// File: rtl/cache_maint_engine.sv
// cache_maint_engine: walks the cache tag array on a maintenance command.
// wb writes back dirty lines and clears their dirty bits; clear writes back
// dirty lines and then invalidates every line. Write-backs use an
// Avalon-style master write port; maint_busy stalls the cache pipeline.
module cache_maint_engine #(
  parameter int unsigned LINE_NUM    = 64,
  parameter int unsigned LINE_WORDS  = 8,
  // Command encodings shared with the control-register block (define.sv)
  parameter logic [2:0]  CMD_CLEAR   = 3'd1,
  parameter logic [2:0]  CMD_WB      = 3'd2,
  localparam int unsigned INDEX_WIDTH  = $clog2(LINE_NUM),
  localparam int unsigned OFFSET_WIDTH = $clog2(LINE_WORDS),
  localparam int unsigned TAG_WIDTH    = 32 - INDEX_WIDTH - OFFSET_WIDTH - 2
) (
  input  logic                              clk,
  input  logic                              rest,
  input  logic [2:0]                        cmd,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  output logic                              maint_busy,
  output logic [INDEX_WIDTH-1:0]            tag_addr,
  output logic                              tag_rd,
  input  logic [TAG_WIDTH+1:0]              tag_rdata,
  output logic                              tag_we,
  output logic [TAG_WIDTH+1:0]              tag_wdata,
  output logic [INDEX_WIDTH+OFFSET_WIDTH-1:0] data_addr,
  output logic                              data_rd,
  input  logic [31:0]                       data_rdata,
  output logic [31:0]                       m0_address,
  output logic [3:0]                        m0_byteEnable,
  output logic                              m0_write,
  output logic [31:0]                       m0_writeData,
  input  logic                              m0_waitRequest
);

  localparam logic [INDEX_WIDTH-1:0]  LAST_IDX  = INDEX_WIDTH'(LINE_NUM - 1);
  localparam logic [OFFSET_WIDTH-1:0] LAST_WORD = OFFSET_WIDTH'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    TAG_RD,
    TAG_CHK,
    WB_RD,
    WB_CAP,
    WB_WR,
    TAG_WR,
    DONE
  } state_t;

  state_t                  state;
  logic [2:0]              cmd_reg;
  logic [INDEX_WIDTH-1:0]  idx;
  logic [OFFSET_WIDTH-1:0] word;
  logic [TAG_WIDTH-1:0]    tag_reg;

  logic [INDEX_WIDTH-1:0]  next_idx;
  logic [OFFSET_WIDTH-1:0] next_word;
  logic                    last_line;
  logic                    rd_valid;
  logic                    rd_dirty;

  // Line/word successors and tag-read field decode
  always_comb begin
    next_idx  = idx + INDEX_WIDTH'(1);
    next_word = word + OFFSET_WIDTH'(1);
    last_line = (idx == LAST_IDX);
    rd_valid  = tag_rdata[TAG_WIDTH+1];
    rd_dirty  = tag_rdata[TAG_WIDTH];
  end

  // Maintenance FSM; every output is a register loaded on the transition
  // into the state that presents it, so no input reaches an output
  // combinationally. One-cycle strobes default low each cycle.
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      state         <= IDLE;
      cmd_reg       <= '0;
      idx           <= '0;
      word          <= '0;
      tag_reg       <= '0;
      cmd_ready     <= 1'b0;
      maint_busy    <= 1'b0;
      tag_addr      <= '0;
      tag_rd        <= 1'b0;
      tag_we        <= 1'b0;
      tag_wdata     <= '0;
      data_addr     <= '0;
      data_rd       <= 1'b0;
      m0_address    <= '0;
      m0_byteEnable <= '0;
      m0_write      <= 1'b0;
      m0_writeData  <= '0;
    end else begin
      tag_rd    <= 1'b0;
      tag_we    <= 1'b0;
      data_rd   <= 1'b0;
      cmd_ready <= 1'b0;

      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            cmd_reg    <= cmd;
            idx        <= '0;
            maint_busy <= 1'b1;
            if (cmd == CMD_WB || cmd == CMD_CLEAR) begin
              state    <= TAG_RD;
              tag_rd   <= 1'b1;
              tag_addr <= '0;
            end else begin
              state     <= DONE;
              cmd_ready <= 1'b1;
            end
          end
        end

        TAG_RD: begin
          state <= TAG_CHK;
        end

        TAG_CHK: begin
          tag_reg <= tag_rdata[TAG_WIDTH-1:0];
          word    <= '0;
          if (rd_valid && rd_dirty) begin
            state     <= WB_RD;
            data_rd   <= 1'b1;
            data_addr <= {idx, {OFFSET_WIDTH{1'b0}}};
          end else if (cmd_reg == CMD_CLEAR) begin
            // tag_reg loads on this same edge, so take the tag from the bus
            state     <= TAG_WR;
            tag_we    <= 1'b1;
            tag_wdata <= {2'b00, tag_rdata[TAG_WIDTH-1:0]};
          end else if (last_line) begin
            state     <= DONE;
            cmd_ready <= 1'b1;
          end else begin
            idx      <= next_idx;
            state    <= TAG_RD;
            tag_rd   <= 1'b1;
            tag_addr <= next_idx;
          end
        end

        WB_RD: begin
          state <= WB_CAP;
        end

        WB_CAP: begin
          // m0_writeData doubles as the captured write-back word
          m0_writeData  <= data_rdata;
          m0_address    <= {tag_reg, idx, word, 2'b00};
          m0_byteEnable <= 4'hF;
          m0_write      <= 1'b1;
          state         <= WB_WR;
        end

        WB_WR: begin
          if (!m0_waitRequest) begin
            m0_write      <= 1'b0;
            m0_byteEnable <= '0;
            if (word == LAST_WORD) begin
              state     <= TAG_WR;
              tag_we    <= 1'b1;
              tag_wdata <= {(cmd_reg == CMD_WB), 1'b0, tag_reg};
            end else begin
              word      <= next_word;
              state     <= WB_RD;
              data_rd   <= 1'b1;
              data_addr <= {idx, next_word};
            end
          end
        end

        TAG_WR: begin
          if (last_line) begin
            state     <= DONE;
            cmd_ready <= 1'b1;
          end else begin
            idx      <= next_idx;
            state    <= TAG_RD;
            tag_rd   <= 1'b1;
            tag_addr <= next_idx;
          end
        end

        DONE: begin
          maint_busy <= 1'b0;
          state      <= IDLE;
        end

        default: begin
          maint_busy <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_maint_engine.sv
// Directed bench for cache_maint_engine with a 4-line, 2-word cache model,
// a stallable write slave and an ordered scoreboard of expected writes.
module tb_cache_maint_engine;

  localparam int unsigned LN = 4;
  localparam int unsigned LW = 2;
  localparam int unsigned IW = 2;
  localparam int unsigned OW = 1;
  localparam int unsigned TW = 27;
  localparam logic [2:0] C_CLEAR = 3'd1;
  localparam logic [2:0] C_WB    = 3'd2;

  logic          clk;
  logic          rest;
  logic [2:0]    cmd;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          maint_busy;
  logic [IW-1:0] tag_addr;
  logic          tag_rd;
  logic [TW+1:0] tag_rdata;
  logic          tag_we;
  logic [TW+1:0] tag_wdata;
  logic [IW+OW-1:0] data_addr;
  logic          data_rd;
  logic [31:0]   data_rdata;
  logic [31:0]   m0_address;
  logic [3:0]    m0_byteEnable;
  logic          m0_write;
  logic [31:0]   m0_writeData;
  logic          m0_waitRequest;

  cache_maint_engine #(
    .LINE_NUM   (LN),
    .LINE_WORDS (LW),
    .CMD_CLEAR  (C_CLEAR),
    .CMD_WB     (C_WB)
  ) dut (
    .clk            (clk),
    .rest           (rest),
    .cmd            (cmd),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .maint_busy     (maint_busy),
    .tag_addr       (tag_addr),
    .tag_rd         (tag_rd),
    .tag_rdata      (tag_rdata),
    .tag_we         (tag_we),
    .tag_wdata      (tag_wdata),
    .data_addr      (data_addr),
    .data_rd        (data_rd),
    .data_rdata     (data_rdata),
    .m0_address     (m0_address),
    .m0_byteEnable  (m0_byteEnable),
    .m0_write       (m0_write),
    .m0_writeData   (m0_writeData),
    .m0_waitRequest (m0_waitRequest)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        kind;   // 0 = m0 write, 1 = tag write
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;
  ev_t sb[$];

  logic [TW+1:0] tmem [LN];
  logic [31:0]   dmem [LN*LW];
  int            stall_req  = 0;
  int            stall_used = 0;
  int            m0_cycles  = 0;
  int            tag_writes = 0;
  logic          held = 1'b0;
  logic [64:0]   saved;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Synchronous tag/data RAMs: read data valid only the cycle after the strobe
  always @(posedge clk) begin
    tag_rdata  <= tag_rd  ? tmem[tag_addr]  : 'x;
    data_rdata <= data_rd ? dmem[data_addr] : 'x;
    if (tag_we) tmem[tag_addr] = tag_wdata;
  end

  // Slave stalls the first stall_req write cycles of each operation
  assign m0_waitRequest = m0_write && (stall_used < stall_req);
  always @(posedge clk) begin
    if (!maint_busy) stall_used <= 0;
    else if (m0_waitRequest) stall_used <= stall_used + 1;
  end

  // Output monitor: pops the scoreboard on completed writes, checks stall hold
  always @(negedge clk) begin
    if (rest) begin
      held = 1'b0;
    end else begin
      if (m0_write) m0_cycles++;
      if (held)
        check("stall_hold", {m0_write, m0_address, m0_writeData}, {1'b1, saved[63:0]});
      held  = m0_write && m0_waitRequest;
      saved = {1'b1, m0_address, m0_writeData};
      if (m0_write && !m0_waitRequest) begin
        check("m0_byteenable", m0_byteEnable, 4'hF);
        check("m0_expected", 128'(sb.size() != 0), 1);
        if (sb.size() != 0) check("m0_write", {1'b0, m0_address, m0_writeData}, sb.pop_front());
      end
      if (tag_we) begin
        tag_writes++;
        check("tag_expected", 128'(sb.size() != 0), 1);
        if (sb.size() != 0) check("tag_write", {1'b1, 32'(tag_addr), 32'(tag_wdata)}, sb.pop_front());
      end
    end
  end

  task automatic push_m0(input logic [31:0] a, input logic [31:0] d);
    sb.push_back({1'b0, a, d});
  endtask

  task automatic push_tag(input int i, input logic [TW+1:0] t);
    sb.push_back({1'b1, 32'(i), 32'(t)});
  endtask

  task automatic load_clean();
    for (int i = 0; i < int'(LN); i++) tmem[i] = {2'b10, TW'(27'h100 + i)};
    for (int i = 0; i < int'(LN*LW); i++) dmem[i] = $urandom;
  endtask

  task automatic start_op(input logic [2:0] c);
    @(negedge clk);
    cmd       = c;
    cmd_valid = 1'b1;
  endtask

  task automatic wait_done(input string name, input int exp, input int start);
    int got = 0;
    logic busy_ok = 1'b1;
    for (int c = start; c <= 300 && got == 0; c++) begin
      @(negedge clk);
      if (!maint_busy) busy_ok = 1'b0;
      if (cmd_ready) begin
        got       = c;
        cmd_valid = 1'b0;
      end
    end
    check({name, "_latency"}, got, exp);
    check({name, "_busy"}, busy_ok, 1'b1);
    @(negedge clk);
    check({name, "_ready_pulse"}, {cmd_ready, maint_busy}, 2'b00);
    check({name, "_sb_drained"}, sb.size(), 0);
  endtask

  initial begin
    int m0_before;
    int tw_before;
    rest      = 1'b1;
    cmd       = C_WB;
    cmd_valid = 1'b1;
    load_clean();

    // Reset held with a pending command: everything stays zero
    repeat (3) begin
      @(negedge clk);
      check("reset_outputs",
            {cmd_ready, maint_busy, tag_addr, tag_rd, tag_we, tag_wdata, data_addr, data_rd,
             m0_address, m0_byteEnable, m0_write, m0_writeData}, '0);
    end
    m0_before = m0_cycles;
    tw_before = tag_writes;
    rest = 1'b0;
    @(negedge clk);
    check("tag_rd_cycle1", {tag_rd, tag_addr}, {1'b1, 2'd0});

    // wb, all clean
    wait_done("wb_clean", 9, 2);
    check("wb_clean_m0", m0_cycles - m0_before, 0);
    check("wb_clean_tagwe", tag_writes - tw_before, 0);

    // wb, one dirty line
    load_clean();
    tmem[2] = {2'b11, 27'h123};
    dmem[4] = 32'hA5A5_0000;
    dmem[5] = 32'h5A5A_1111;
    push_m0(32'h2470, 32'hA5A5_0000);
    push_m0(32'h2474, 32'h5A5A_1111);
    push_tag(2, {2'b10, 27'h123});
    start_op(C_WB);
    wait_done("wb_dirty", 16, 1);
    check("wb_dirty_tag2", tmem[2], {2'b10, 27'h123});

    // clear, one dirty line: write-backs precede that line's tag write
    load_clean();
    tmem[1] = {2'b11, 27'h4567};
    dmem[2] = 32'h1357_9BDF;
    dmem[3] = 32'h0246_8ACE;
    push_tag(0, {2'b00, 27'h100});
    push_m0({27'h4567, 2'd1, 1'b0, 2'b00}, 32'h1357_9BDF);
    push_m0({27'h4567, 2'd1, 1'b1, 2'b00}, 32'h0246_8ACE);
    push_tag(1, {2'b00, 27'h4567});
    push_tag(2, {2'b00, 27'h102});
    push_tag(3, {2'b00, 27'h103});
    start_op(C_CLEAR);
    wait_done("clear_dirty", 19, 1);
    check("clear_tag3", tmem[3], {2'b00, 27'h103});

    // waitRequest stall on the first write-back
    load_clean();
    tmem[2] = {2'b11, 27'h123};
    dmem[4] = 32'hA5A5_0000;
    dmem[5] = 32'h5A5A_1111;
    stall_req = 3;
    push_m0(32'h2470, 32'hA5A5_0000);
    push_m0(32'h2474, 32'h5A5A_1111);
    push_tag(2, {2'b10, 27'h123});
    start_op(C_WB);
    wait_done("wb_stall", 19, 1);
    stall_req = 0;

    // Unrecognised command completes immediately
    start_op(3'd7);
    wait_done("bad_cmd", 1, 1);

    // Reset in the middle of a stalled write-back
    load_clean();
    tmem[2] = {2'b11, 27'h123};
    stall_req = 100;
    start_op(C_WB);
    for (int c = 0; c < 100 && !m0_write; c++) @(negedge clk);
    check("mid_m0_write_seen", m0_write, 1'b1);
    rest = 1'b1;
    #1;
    check("mid_reset_outputs", {m0_write, maint_busy}, 2'b00);
    cmd_valid = 1'b0;
    stall_req = 0;
    repeat (2) begin
      @(negedge clk);
      check("mid_reset_ready", {cmd_ready, maint_busy}, 2'b00);
    end
    rest = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("mid_after_ready", {cmd_ready, maint_busy}, 2'b00);
    end
    check("mid_tag2_kept", tmem[2], {2'b11, 27'h123});
    check("mid_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
